prg_seq: RTL
============

Name: prg_seq

Overview:
- Multi-cycle instruction sequencer for the 4-bit CPU core, parametrised in data and address width.
- Owns the program counter, instruction register, carry flag and a memory request/acknowledge handshake.
- Faults on illegal memory or I/O accesses and on memory timeouts.
- Sits between the program ROM and the datapath (R0/R1 registers, ALU, user memory, memory-mapped I/O). Its one-cycle load strobes drive the datapath registers.

Parameters:
- DW, 4, datapath/immediate width; instruction word is 4+DW bits (opcode [DW+3:DW], immediate [DW-1:0]); AW<=DW is required.
- AW, 4, program and memory address width.
- P_MEM, 4'hC, highest user-memory address.
- P_IOIN, 4'hD, input port address (read-only).
- P_IOOUT, 4'hE, output port address (write-only).
- TMO, 8, maximum wait cycles for MEM_ACK; range 1..255.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- RUN  in  1  execute enable
- MC_CODE  in  4+DW  instruction word at PRG_CNT
- CARRY  in  1  ALU carry-out for the current operation
- R1_REG  in  DW  R1 register value
- MEM_ACK  in  1  memory/I-O access complete
- PRG_CNT  out  AW  program counter
- ALU_SEL  out  4  ALU operand/operation select
- R0_LD  out  1  R0 load strobe
- R1_LD  out  1  R1 load strobe
- OUT_LD  out  1  output port load strobe
- CARRY_LD  out  1  carry capture strobe
- MEM_A  out  AW  memory address
- MEM_REQ  out  1  memory access request
- MEM_WE  out  1  1=write, 0=read, valid with MEM_REQ
- CARRY_FLG  out  1  registered carry flag
- FAULT  out  1  sticky fault
- STATE  out  3  FSM state, for debug

Behaviour:
- Reset (RST_N=0, asynchronous): STATE=IDLE, PRG_CNT=0, IR=0, CARRY_FLG=0, FAULT=0, wait counter=0. All strobes, MEM_REQ and MEM_WE are 0, MEM_A=0, ALU_SEL=0.
- Reset asserted mid-access drops MEM_REQ in the same cycle; no strobe is emitted.
- States:
  - IDLE=0: RUN=1 -> FETCH.
  - FETCH=1: IR<=MC_CODE -> EXEC.
  - EXEC=2: decode IR.
  - MEMW=3: wait for MEM_ACK.
  - FAULT=4: absorbing; left only by reset.
- Instruction completion: PC update occurs at end of EXEC for non-memory ops and on the MEM_ACK cycle for memory ops. Next state is FETCH if RUN=1, else IDLE.
- Strobes are 1 for exactly one cycle per instruction:
  - Non-memory ops: in EXEC.
  - Memory loads: in MEMW on the MEM_ACK=1 cycle (Mealy).
  - ALU_SEL is held through EXEC and MEMW.
- Opcode map (ALU_SEL, strobes):
  - 0 MOV R0,Im: sel 0, R0_LD.
  - 1 MOV R1,Im: sel 0, R1_LD.
  - 2 MOV @R1,R0: sel 3, write to R1_REG[AW-1:0].
  - 3 MOV R0,@R1: sel 1, read from R1_REG[AW-1:0], R0_LD.
  - 4 MOV @Im,R0: sel 3, write to Im[AW-1:0].
  - 5 MOV R0,@Im: sel 1, read, R0_LD.
  - 6 MOV @Im,R1: sel 4, write.
  - 7 MOV R1,@Im: sel 1, read, R1_LD.
  - 8 MOV R1,R0: sel 3, R1_LD.
  - 9 IIN Im: sel 2, R0_LD.
  - A ADD R0,Im: sel 5, R0_LD+CARRY_LD.
  - B ADD R1,Im: sel 6, R1_LD+CARRY_LD.
  - C ADD R0,R1: sel 7, R0_LD+CARRY_LD.
  - D JMP Im: sel 0, PC<=Im[AW-1:0].
  - E JNC Im: jump if CARRY_FLG=0, else PC+1.
  - F SUB R0,R1: sel 8, R0_LD+CARRY_LD.
- CARRY_FLG<=CARRY on the CARRY_LD cycle; otherwise unchanged. JNC tests CARRY_FLG, never live CARRY.
- PC increment wraps modulo 2^AW (max -> 0). JMP/JNC to any address is legal.
- Memory ops in EXEC: address legality is checked combinationally.
  - Read is legal if addr<=P_MEM or addr==P_IOIN.
  - Write is legal if addr<=P_MEM or addr==P_IOOUT.
  - Illegal: FAULT<=1, STATE->FAULT, no MEM_REQ, no strobe, PC frozen.
  - Legal: -> MEMW, MEM_REQ=1, MEM_WE=write, MEM_A registered, counter cleared.
- MEMW:
  - MEM_REQ stays 1 until and including the MEM_ACK cycle, then drops.
  - OUT_LD=1 on the ack cycle of a write with MEM_A==P_IOOUT.
  - Counter increments each non-ack cycle. If the counter reaches TMO with MEM_ACK=0: FAULT, MEM_REQ drops next cycle.
  - MEM_ACK on the same cycle the counter reaches TMO counts as success.
- MEM_ACK outside MEMW is ignored.
- RUN deasserted mid-instruction: the instruction completes, then IDLE. PRG_CNT is held in IDLE.
- FAULT state: all strobes and MEM_REQ are 0; PRG_CNT holds the faulting instruction's address.
- Latency:
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - Memory instruction: 3+W cycles, where W is the number of MEM_ACK wait cycles.

Test Plan:
- Reset, RUN=1, ROM {0:0x05, 1:0xA3}, CARRY=0 -> R0_LD pulses in cycle 2 with ALU_SEL=0; cycle 4 has R0_LD+CARRY_LD with ALU_SEL=5; PRG_CNT=2, CARRY_FLG=0.
- ROM {0:0xA1} with CARRY=1, then 1:0xE7 -> CARRY_FLG=1, JNC falls through to PRG_CNT=2. Repeat with CARRY=0 -> PRG_CNT=7.
- ROM 0:0x4E, MEM_ACK after 3 cycles -> MEM_REQ high 4 cycles, MEM_WE=1, MEM_A=0xE, OUT_LD pulses on the ack cycle, PRG_CNT=1.
- ROM 0:0x5E (read of the output port) -> FAULT=1 and STATE=4 after EXEC, no MEM_REQ, PRG_CNT=0. RST_N pulse clears FAULT.
- ROM 0:0x53, MEM_ACK held 0 -> FAULT after TMO=8 wait cycles. Same access with ack exactly on the 8th cycle -> success, R0_LD pulses.
- PRG_CNT=0xF executing 0x00 -> PRG_CNT wraps to 0. RST_N low during MEMW -> MEM_REQ=0 immediately, STATE=0.

Source files
------------

// File: rtl/prg_seq.sv
// Multi-cycle instruction sequencer for the 4-bit CPU core: program counter, IR, carry flag,
// memory request/acknowledge handshake with address legality check and timeout fault.
module prg_seq #(
  parameter int unsigned     DW      = 4,
  parameter int unsigned     AW      = 4,
  parameter logic [AW-1:0]   P_MEM   = AW'(4'hC),
  parameter logic [AW-1:0]   P_IOIN  = AW'(4'hD),
  parameter logic [AW-1:0]   P_IOOUT = AW'(4'hE),
  parameter int unsigned     TMO     = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_run,
  input  logic [DW+3:0]   i_mc_code,
  input  logic            i_carry,
  input  logic [DW-1:0]   i_r1_reg,
  input  logic            i_mem_ack,
  output logic [AW-1:0]   o_prg_cnt,
  output logic [3:0]      o_alu_sel,
  output logic            o_r0_ld,
  output logic            o_r1_ld,
  output logic            o_out_ld,
  output logic            o_carry_ld,
  output logic [AW-1:0]   o_mem_a,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic            o_carry_flg,
  output logic            o_fault,
  output logic [2:0]      o_state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StExec  = 3'd2,
    StMemw  = 3'd3,
    StFault = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0] sel;
    logic       r0;
    logic       r1;
    logic       cld;
    logic       rd;
    logic       wr;
  } dec_t;

  function automatic dec_t f_dec(input logic [3:0] op);
    dec_t d;
    d = '0;
    unique case (op)
      4'h0: d.r0 = 1'b1;
      4'h1: d.r1 = 1'b1;
      4'h2: begin d.sel = 4'd3; d.wr = 1'b1; end
      4'h3: begin d.sel = 4'd1; d.rd = 1'b1; d.r0 = 1'b1; end
      4'h4: begin d.sel = 4'd3; d.wr = 1'b1; end
      4'h5: begin d.sel = 4'd1; d.rd = 1'b1; d.r0 = 1'b1; end
      4'h6: begin d.sel = 4'd4; d.wr = 1'b1; end
      4'h7: begin d.sel = 4'd1; d.rd = 1'b1; d.r1 = 1'b1; end
      4'h8: begin d.sel = 4'd3; d.r1 = 1'b1; end
      4'h9: begin d.sel = 4'd2; d.r0 = 1'b1; end
      4'hA: begin d.sel = 4'd5; d.r0 = 1'b1; d.cld = 1'b1; end
      4'hB: begin d.sel = 4'd6; d.r1 = 1'b1; d.cld = 1'b1; end
      4'hC: begin d.sel = 4'd7; d.r0 = 1'b1; d.cld = 1'b1; end
      4'hD: d.sel = 4'd0;
      4'hE: d.sel = 4'd0;
      4'hF: begin d.sel = 4'd8; d.r0 = 1'b1; d.cld = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

  state_e          r_state;
  logic [DW+3:0]   r_ir;
  logic [AW-1:0]   r_prg_cnt;
  logic [AW-1:0]   r_mem_a;
  logic [3:0]      r_alu_sel;
  logic [7:0]      r_cnt;
  logic            r_r0_ld, r_r1_ld, r_carry_ld;
  logic            r_mem_req, r_mem_we, r_carry_flg, r_fault;

  logic [3:0]      w_op;
  dec_t            w_dir, w_dfe;
  logic [AW-1:0]   w_addr, w_pc_inc, w_pc_nxt;
  logic            w_mem, w_legal, w_ack;

  assign w_op     = r_ir[DW+3:DW];
  assign w_dir    = f_dec(w_op);
  assign w_dfe    = f_dec(i_mc_code[DW+3:DW]);
  assign w_mem    = w_dir.rd | w_dir.wr;
  assign w_addr   = (w_op == 4'h2 || w_op == 4'h3) ? i_r1_reg[AW-1:0] : r_ir[AW-1:0];
  assign w_legal  = (w_addr <= P_MEM) | (w_dir.rd & (w_addr == P_IOIN)) |
                    (w_dir.wr & (w_addr == P_IOOUT));
  assign w_pc_inc = r_prg_cnt + AW'(1);
  assign w_ack    = (r_state == StMemw) & i_mem_ack;

  // JNC tests the registered flag, never the live ALU carry
  always_comb begin
    w_pc_nxt = w_pc_inc;
    if (w_op == 4'hD) w_pc_nxt = r_ir[AW-1:0];
    else if (w_op == 4'hE && !r_carry_flg) w_pc_nxt = r_ir[AW-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_ir        <= '0;
      r_prg_cnt   <= '0;
      r_mem_a     <= '0;
      r_alu_sel   <= '0;
      r_cnt       <= '0;
      r_r0_ld     <= 1'b0;
      r_r1_ld     <= 1'b0;
      r_carry_ld  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_carry_flg <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: if (i_run) r_state <= StFetch;
        StFetch: begin
          // non-memory strobes are pre-decoded so they are registered for the EXEC cycle
          r_ir       <= i_mc_code;
          r_alu_sel  <= w_dfe.sel;
          r_r0_ld    <= w_dfe.r0 & ~(w_dfe.rd | w_dfe.wr);
          r_r1_ld    <= w_dfe.r1 & ~(w_dfe.rd | w_dfe.wr);
          r_carry_ld <= w_dfe.cld;
          r_state    <= StExec;
        end
        StExec: begin
          r_r0_ld    <= 1'b0;
          r_r1_ld    <= 1'b0;
          r_carry_ld <= 1'b0;
          if (r_carry_ld) r_carry_flg <= i_carry;
          if (w_mem && w_legal) begin
            r_mem_req <= 1'b1;
            r_mem_we  <= w_dir.wr;
            r_mem_a   <= w_addr;
            r_cnt     <= '0;
            r_state   <= StMemw;
          end else if (w_mem) begin
            r_alu_sel <= '0;
            r_fault   <= 1'b1;
            r_state   <= StFault;
          end else begin
            r_alu_sel <= '0;
            r_prg_cnt <= w_pc_nxt;
            r_state   <= i_run ? StFetch : StIdle;
          end
        end
        StMemw: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_alu_sel <= '0;
            r_prg_cnt <= w_pc_inc;
            r_state   <= i_run ? StFetch : StIdle;
          end else if (r_cnt == 8'(TMO)) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_alu_sel <= '0;
            r_fault   <= 1'b1;
            r_state   <= StFault;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StFault: r_state <= StFault;
        default: r_state <= StFault;
      endcase
    end
  end

  // memory-load strobes follow the acknowledge combinationally
  assign o_r0_ld     = r_r0_ld | (w_ack & w_dir.r0);
  assign o_r1_ld     = r_r1_ld | (w_ack & w_dir.r1);
  assign o_out_ld    = w_ack & r_mem_we & (r_mem_a == P_IOOUT);
  assign o_carry_ld  = r_carry_ld;
  assign o_prg_cnt   = r_prg_cnt;
  assign o_alu_sel   = r_alu_sel;
  assign o_mem_a     = r_mem_a;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_carry_flg = r_carry_flg;
  assign o_fault     = r_fault;
  assign o_state     = r_state;

endmodule
